// File: rtl/shift_rot_pipe.sv
// Registered log2(WIDTH)-stage shift/rotate pipeline with valid/ready flow.
// Define SHIFT_ROT_ARITH_EN to enable sign-fill for mode 10 right shifts.
module shift_rot_pipe #(
    parameter  int WIDTH = 32,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_amt,
    input  logic [1:0]       in_mode,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] d_q [SW];
    logic [SW-1:0]    a_q [SW];
    logic [1:0]       m_q [SW];
    logic [SW-1:0]    r_q;
    logic [SW-1:0]    v_q;

    logic [WIDTH-1:0] s_d [SW];
    logic [SW-1:0]    s_a [SW];
    logic [1:0]       s_m [SW];
    logic [SW-1:0]    s_r;
    logic [SW-1:0]    s_v;
    logic [WIDTH-1:0] nxt [SW];

    logic stall;

    assign stall     = v_q[SW-1] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = v_q[SW-1];
    assign out_data  = d_q[SW-1];

    always_comb begin
        for (int k = 0; k < SW; k++) begin
            if (k == 0) begin
                s_d[k] = in_data;
                s_a[k] = in_amt;
                s_m[k] = in_mode;
                s_r[k] = in_dir;
                s_v[k] = in_valid;
            end else begin
                s_d[k] = d_q[k-1];
                s_a[k] = a_q[k-1];
                s_m[k] = m_q[k-1];
                s_r[k] = r_q[k-1];
                s_v[k] = v_q[k-1];
            end
        end
    end

    // Stage k moves the word by 2^k; earlier stages already preserve the MSB
    // for arithmetic right shifts, so the local MSB is the original sign.
    always_comb begin
        for (int k = 0; k < SW; k++) begin
            int sh;
            logic [WIDTH-1:0] x;
            sh     = 1 << k;
            x      = s_d[k];
            nxt[k] = x;
            if (s_a[k][k]) begin
                if (s_m[k] == 2'b01) begin
                    if (s_r[k])
                        nxt[k] = (x << sh) | (x >> (WIDTH - sh));
                    else
                        nxt[k] = (x >> sh) | (x << (WIDTH - sh));
                end else if (s_r[k]) begin
                    nxt[k] = x << sh;
`ifdef SHIFT_ROT_ARITH_EN
                end else if (s_m[k] == 2'b10) begin
                    nxt[k] = $signed(x) >>> sh;
`endif
                end else begin
                    nxt[k] = x >> sh;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            v_q <= '0;
            for (int k = 0; k < SW; k++) begin
                d_q[k] <= '0;
                a_q[k] <= '0;
                m_q[k] <= '0;
            end
        end else if (!stall) begin
            r_q <= s_r;
            v_q <= s_v;
            for (int k = 0; k < SW; k++) begin
                d_q[k] <= nxt[k];
                a_q[k] <= s_a[k];
                m_q[k] <= s_m[k];
            end
        end
    end

endmodule
